// File: rtl/mc_pkg.sv
// mc_pkg: shared PC-source encoding, opcodes and datapath width for the multicycle MIPS slice
package mc_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
endpackage

// File: rtl/flopenr.sv
// flopenr: enable register with asynchronous active-low reset to a parameterised value
module flopenr #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/mc_datapath_regs.sv
// mc_datapath_regs: PC, IR, MDR, A, B, ALUOut, next-PC select and performance counters
module mc_datapath_regs
  import mc_pkg::*;
#(
  parameter int WIDTH = mc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic [1:0]       PCSource,
  input  logic             IorD,
  input  logic [WIDTH-1:0] mem_rd,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mem_addr,
  output logic             pc_en,
  output logic             pcsrc_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  logic [WIDTH-1:0] nextPc;
  logic [WIDTH-1:0] jumpTarget;
  logic pcReq;
  logic pcSrcBad;
  always_comb begin
    pcReq      = PCWrite | (Branch & zero);
    pcSrcBad   = PCSource == 2'b11;
    pc_en      = pcReq & ~pcSrcBad;
    jumpTarget = {pc[WIDTH-1:WIDTH-4], instr[WIDTH-7:0], 2'b00};
    nextPc     = PCSource == PCSRC_ALU    ? alu_result :
                 PCSource == PCSRC_ALUOUT ? alu_out    : jumpTarget;
    mem_addr   = IorD ? alu_out : pc;
    op         = instr[WIDTH-1:WIDTH-6];
  end
  flopenr #(.W(WIDTH), .RST_VAL(RESET_PC)) pcReg (
    .clk(clk), .rst_n(rst_n), .en(pc_en), .d(nextPc), .q(pc));
  flopenr #(.W(WIDTH)) irReg (
    .clk(clk), .rst_n(rst_n), .en(IRWrite), .d(mem_rd), .q(instr));
  flopenr #(.W(WIDTH)) mdrReg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(mem_rd), .q(mdr));
  flopenr #(.W(WIDTH)) aReg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(rd1), .q(a));
  flopenr #(.W(WIDTH)) bReg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(rd2), .q(b));
  flopenr #(.W(WIDTH)) aluOutReg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(alu_result), .q(alu_out));
  // Any PC request with PCSource=11 is flagged, even a branch whose zero is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcsrc_err   <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      pcsrc_err   <= pcsrc_err | ((PCWrite | Branch) & pcSrcBad);
      cycle_count <= cycle_count + 1'b1;
      instr_count <= instr_count + CNT_W'(IRWrite);
    end
endmodule

// File: tb/tb_mc_datapath_regs.sv
// tb_mc_datapath_regs: directed checks of the multicycle datapath registers
module tb_mc_datapath_regs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        IRWrite, PCWrite, Branch, IorD, zero;
  logic [1:0]  PCSource;
  logic [31:0] mem_rd, rd1, rd2, alu_result;
  logic [31:0] pc, instr, mdr, a, b, alu_out, mem_addr;
  logic [5:0]  op;
  logic        pc_en, pcsrc_err;
  logic [31:0] cycle_count, instr_count;
  int nAsserts = 0;
  int nFail = 0;
  int expCycles = 0;
  mc_datapath_regs dut (
    .clk(clk), .rst_n(rst_n), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCSource(PCSource), .IorD(IorD), .mem_rd(mem_rd), .rd1(rd1), .rd2(rd2),
    .alu_result(alu_result), .zero(zero), .pc(pc), .instr(instr), .op(op), .mdr(mdr),
    .a(a), .b(b), .alu_out(alu_out), .mem_addr(mem_addr), .pc_en(pc_en),
    .pcsrc_err(pcsrc_err), .cycle_count(cycle_count), .instr_count(instr_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    expCycles++;
  endtask
  task automatic chkReset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_op"}, {26'h0, op}, 32'h0);
    chk({tag, "_mdr"}, mdr, 32'h0);
    chk({tag, "_a"}, a, 32'h0);
    chk({tag, "_b"}, b, 32'h0);
    chk({tag, "_aluout"}, alu_out, 32'h0);
    chk({tag, "_cyc"}, cycle_count, 32'h0);
    chk({tag, "_icnt"}, instr_count, 32'h0);
    chk({tag, "_err"}, {31'h0, pcsrc_err}, 32'h0);
  endtask
  initial begin
    rst_n = 1'b0; IRWrite = 0; PCWrite = 0; Branch = 0; IorD = 0; zero = 0; PCSource = 2'b00;
    mem_rd = 0; rd1 = 0; rd2 = 0; alu_result = 0;
    #3;
    chkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Fetch LW
    mem_rd = 32'h8C08_0004; IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'h4;
    rd1 = 32'h11; rd2 = 32'h22;
    #1;
    chk("fetch_memaddr", mem_addr, 32'h0);
    chk("fetch_pcen", {31'h0, pc_en}, 32'h1);
    step();
    chk("fetch_instr", instr, 32'h8C08_0004);
    chk("fetch_op", {26'h0, op}, 32'h23);
    chk("fetch_pc", pc, 32'h4);
    chk("fetch_icnt", instr_count, 32'h1);
    chk("fetch_cyc", cycle_count, 32'(expCycles));
    chk("fetch_mdr", mdr, 32'h8C08_0004);
    chk("fetch_a", a, 32'h11);
    chk("fetch_b", b, 32'h22);
    chk("fetch_aluout", alu_out, 32'h4);
    // Preload ALUOut with the branch target
    IRWrite = 0; PCWrite = 0; alu_result = 32'h20; mem_rd = 32'h1234_5678;
    step();
    chk("pre_aluout", alu_out, 32'h20);
    chk("pre_pc", pc, 32'h4);
    chk("pre_instr", instr, 32'h8C08_0004);
    chk("pre_icnt", instr_count, 32'h1);
    // BEQ taken
    Branch = 1; PCSource = 2'b01; zero = 1; alu_result = 32'h99;
    #1;
    chk("beq_t_pcen", {31'h0, pc_en}, 32'h1);
    step();
    chk("beq_t_pc", pc, 32'h20);
    // BEQ not taken
    zero = 0;
    #1;
    chk("beq_nt_pcen", {31'h0, pc_en}, 32'h0);
    step();
    chk("beq_nt_pc", pc, 32'h20);
    // PCWrite with Branch loads regardless of zero
    PCWrite = 1; PCSource = 2'b00; alu_result = 32'h30;
    step();
    chk("pcw_br_pc", pc, 32'h30);
    // Set up PC and IR for a jump
    Branch = 0; IRWrite = 1; mem_rd = 32'h0800_0010; alu_result = 32'h1000_0004;
    step();
    chk("jset_pc", pc, 32'h1000_0004);
    chk("jset_op", {26'h0, op}, 32'h02);
    IRWrite = 0; PCSource = 2'b10; alu_result = 32'h0;
    step();
    chk("jump_pc", pc, 32'h1000_0040);
    chk("jump_icnt", instr_count, 32'h2);
    // IorD
    PCWrite = 0; PCSource = 2'b00; alu_result = 32'h44;
    step();
    IorD = 1; alu_result = 32'h55;
    #1;
    chk("iord1_addr", mem_addr, 32'h44);
    IorD = 0;
    #1;
    chk("iord0_addr", mem_addr, 32'h1000_0040);
    // Illegal PCSource
    PCWrite = 1; PCSource = 2'b11; alu_result = 32'hDEAD;
    #1;
    chk("ill_pcen", {31'h0, pc_en}, 32'h0);
    chk("ill_err_pre", {31'h0, pcsrc_err}, 32'h0);
    step();
    chk("ill_pc", pc, 32'h1000_0040);
    chk("ill_err", {31'h0, pcsrc_err}, 32'h1);
    PCWrite = 0; PCSource = 2'b00;
    step();
    chk("ill_err_sticky", {31'h0, pcsrc_err}, 32'h1);
    chk("cyc_before_rst", cycle_count, 32'(expCycles));
    // Asynchronous reset between edges
    rst_n = 1'b0;
    #2;
    chkReset("async");
    #1;
    rst_n = 1'b1;
    alu_result = 32'h0;
    step();
    chk("post_cyc", cycle_count, 32'h1);
    chk("post_icnt", instr_count, 32'h0);
    chk("post_pc", pc, 32'h0);
    chk("post_err", {31'h0, pcsrc_err}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Sequential half of the multicycle MIPS datapath. Sits directly downstream of `control_fsm` and feeds it: it consumes the FSM's register-enable and mux-select outputs, holds the PC and the non-architectural registers (IR, MDR, A, B, ALUOut), and drives the `op` field back into `control_fsm`. It also computes the next-PC selection and keeps cycle and instruction performance counters.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `CNT_W`, 32, performance counter width

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `IRWrite`  in  1  load IR from `mem_rd`
- `PCWrite`  in  1  unconditional PC load
- `Branch`  in  1  conditional PC load, qualified by `zero`
- `PCSource`  in  2  next-PC select
- `IorD`  in  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_rd`  in  WIDTH  memory read data
- `rd1`, `rd2`  in  WIDTH  register-file read data
- `alu_result`  in  WIDTH  combinational ALU output
- `zero`  in  1  ALU zero flag
- `pc`  out  WIDTH  program counter
- `instr`  out  WIDTH  instruction register
- `op`  out  6  `instr[31:26]`, to `control_fsm`
- `mdr`, `a`, `b`, `alu_out`  out  WIDTH  non-architectural registers
- `mem_addr`  out  WIDTH  `IorD ? alu_out : pc`, combinational
- `pc_en`  out  1  PC load enable this cycle, combinational
- `pcsrc_err`  out  1  sticky illegal-PCSource flag
- `cycle_count`, `instr_count`  out  CNT_W  performance counters

## Operation
- Reset (`rst_n`=0, asynchronous, no clock needed):
  - `pc`=RESET_PC.
  - `instr`, `mdr`, `a`, `b`, `alu_out`, counters and `pcsrc_err` all 0.
  - `op` is therefore 6'b000000.
- IR loads `mem_rd` on a rising edge when `IRWrite`=1. Otherwise it holds.
- MDR, A, B and ALUOut load every edge, unconditionally: MDR←`mem_rd`, A←`rd1`, B←`rd2`, ALUOut←`alu_result`.
- Next PC by `PCSource`:
  - 00 = `alu_result`
  - 01 = `alu_out`
  - 10 = jump target `{pc[31:28], instr[25:0], 2'b00}`
  - 11 = illegal
- `pc_en` = (`PCWrite` | (`Branch` & `zero`)) & (`PCSource`≠11).
  - `PCWrite` and `Branch` together: the PC loads regardless of `zero`.
- Illegal `PCSource`=11 with a PCWrite/Branch request:
  - PC holds.
  - `pcsrc_err` sets and stays set until reset.
- `Branch`=1 with `zero`=0 and `PCWrite`=0: PC holds.
- Counters:
  - `cycle_count` increments on every edge out of reset.
  - `instr_count` increments on each edge where `IRWrite`=1.
  - Both wrap modulo 2^CNT_W with no flag.

## Timing
- All register updates occur on the rising `clk` edge; `rst_n` overrides asynchronously.
- `op` changes one edge after `IRWrite`, so the FSM sees the new opcode in the Decode cycle.
- Fetch cycle with `IRWrite`=`PCWrite`=1:
  - IR captures the instruction addressed by the old PC.
  - PC captures PC+4 on the same edge.
  - `mem_addr` uses the pre-edge PC during that cycle.
- Jump target uses the current `pc` and `instr`, meaning the values present before the edge.
- `mem_addr` and `pc_en` are combinational, zero latency from their inputs.
- Reset asserted mid-instruction: all state returns to reset values immediately. After `rst_n` deasserts, the first edge resumes counting from 0.

## Structure
- Shared package `mc_pkg` holds:
  - `pcsrc_t` enum: PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10.
  - Opcode constants: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_ADDI=001000, OP_J=000010.
  - `WIDTH` default.
- Natural sub-module: `flopenr`, a parameterised enable register with async active-low reset and a reset-value parameter. It is instantiated for PC, IR, MDR, A, B and ALUOut.

## Test plan
- Reset: hold `rst_n`=0 with no clock edges → `pc`=0, `instr`=0, `op`=000000, both counters 0, `pcsrc_err`=0.
- Fetch LW:
  - Stimulus: `mem_rd`=32'h8C08_0004, `IRWrite`=`PCWrite`=1, `PCSource`=00, `alu_result`=4.
  - After one edge: `instr`=32'h8C08_0004, `op`=100011, `pc`=4, `instr_count`=1.
- BEQ:
  - Preload `alu_out`=32'h20, then `Branch`=1, `PCSource`=01.
  - `zero`=1 → `pc`=32'h20 after the edge.
  - Repeat with `zero`=0 → `pc` unchanged.
- J:
  - Stimulus: `pc`=32'h1000_0004, `instr`=32'h0800_0010, `PCWrite`=1, `PCSource`=10.
  - After the edge: `pc`=32'h1000_0040.
- IorD:
  - `alu_out`=32'h44, `IorD`=1 → `mem_addr`=32'h44 in the same cycle.
  - `IorD`=0 → `mem_addr`=`pc`.
- Error and async reset:
  - `PCWrite`=1, `PCSource`=11 → `pc` holds, `pcsrc_err`=1 and stays 1.
  - Pulse `rst_n` low between edges → all outputs at reset values before the next edge.
